tmr_err_monitor: RTL and testbench

//  Collects tmrErr flags from N majority voters and turns them into software-visible status.

---
 rtl/tmr_err_monitor_if.sv | 48 ++++
 rtl/tmr_err_monitor.sv | 152 +++++++++++++++
 tb/tb_tmr_err_monitor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_err_monitor_if.sv
// Signal bundle between the TMR voter array / software side and tmr_err_monitor.
// master drives the voter error lines, enable, threshold and clear request;
// slave (the monitor) returns the clear acknowledge and status fields.
interface tmr_err_monitor_if #(
    parameter int N_VOTERS  = 8,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 3
);
    logic [N_VOTERS-1:0]  err_i;
    logic                 enable_i;
    logic [CNT_WIDTH-1:0] thresh_i;
    logic                 clr_req_i;
    logic                 clr_ack_o;
    logic [N_VOTERS-1:0]  sticky_o;
    logic [CNT_WIDTH-1:0] err_cnt_o;
    logic                 cnt_sat_o;
    logic                 first_valid_o;
    logic [IDX_WIDTH-1:0] first_idx_o;
    logic                 irq_o;

    modport master (
        output err_i,
        output enable_i,
        output thresh_i,
        output clr_req_i,
        input  clr_ack_o,
        input  sticky_o,
        input  err_cnt_o,
        input  cnt_sat_o,
        input  first_valid_o,
        input  first_idx_o,
        input  irq_o
    );

    modport slave (
        input  err_i,
        input  enable_i,
        input  thresh_i,
        input  clr_req_i,
        output clr_ack_o,
        output sticky_o,
        output err_cnt_o,
        output cnt_sat_o,
        output first_valid_o,
        output first_idx_o,
        output irq_o
    );
endinterface

// File: rtl/tmr_err_monitor.sv
// TMR voter error monitor: sticky flags, saturating event counter,
// first-failing index and threshold IRQ, cleared by a 4-phase clr_req/clr_ack.
// Ports: clk, rst (async, active-high), bus (tmr_err_monitor_if.slave).
module tmr_err_monitor #(
    parameter int N_VOTERS  = 8,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tmr_err_monitor_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [N_VOTERS-1:0]  r_err_q;
    logic [N_VOTERS-1:0]  r_err_d;
    logic [N_VOTERS-1:0]  w_rise;
    logic [N_VOTERS-1:0]  r_sticky;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_sat;
    logic                 r_fv;
    logic [IDX_WIDTH-1:0] r_fidx;
    logic [IDX_WIDTH-1:0] w_low_idx;
    logic                 r_irq;
    logic                 r_ack;
    logic                 w_upd;
    logic                 w_irq_hit;

    // Two-stage input register: err_q is the sampled level, err_d its
    // previous value, so an error held across reset release still rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_q <= '0;
            r_err_d <= '0;
        end else begin
            r_err_q <= bus.err_i;
            r_err_d <= r_err_q;
        end
    end

    assign w_rise = r_err_q & ~r_err_d;
    assign w_upd  = bus.enable_i & (|w_rise) & (r_state != S_CLR);

    // Lowest set index: scan downwards so the last hit wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_VOTERS - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_low_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    assign w_irq_hit = (bus.thresh_i != '0) && (w_cnt_nxt >= bus.thresh_i);

    // Clear handshake FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.clr_req_i) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (!bus.clr_req_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered ack so it rises exactly with the CLR->ACK edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= (w_state_nxt == S_ACK);
        end
    end

    // Status registers. The CLR cycle both clears and drops any event
    // arriving in it, so clear always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_fv     <= 1'b0;
            r_fidx   <= '0;
            r_irq    <= 1'b0;
        end else if (r_state == S_CLR) begin
            r_sticky <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_fv     <= 1'b0;
            r_fidx   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (bus.enable_i) begin
                r_sticky <= r_sticky | r_err_q;
            end
            if (w_upd) begin
                r_cnt <= w_cnt_nxt;
                r_sat <= (w_cnt_nxt == CNT_MAX);
                if (w_irq_hit) begin
                    r_irq <= 1'b1;
                end
                if (!r_fv) begin
                    r_fv   <= 1'b1;
                    r_fidx <= w_low_idx;
                end
            end
        end
    end

    assign bus.clr_ack_o     = r_ack;
    assign bus.sticky_o      = r_sticky;
    assign bus.err_cnt_o     = r_cnt;
    assign bus.cnt_sat_o     = r_sat;
    assign bus.first_valid_o = r_fv;
    assign bus.first_idx_o   = r_fidx;
    assign bus.irq_o         = r_irq;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Testbench for tmr_err_monitor: directed scenarios plus random traffic,
// two builds (16-bit and 4-bit counter) checked against a behavioural model.
module tb_tmr_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] th;

    int n_chk = 0;
    int n_err = 0;

    tmr_err_monitor_if #(.N_VOTERS(8), .CNT_WIDTH(16), .IDX_WIDTH(3)) bus16 ();
    tmr_err_monitor_if #(.N_VOTERS(8), .CNT_WIDTH(4),  .IDX_WIDTH(3)) bus4 ();

    tmr_err_monitor #(.N_VOTERS(8), .CNT_WIDTH(16), .IDX_WIDTH(3)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    tmr_err_monitor #(.N_VOTERS(8), .CNT_WIDTH(4), .IDX_WIDTH(3)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: w=0 is the 16-bit build, w=1 the 4-bit build
    bit [7:0] m_q, m_d, m_sticky;
    int       m_cnt [2];
    bit       m_irq [2];
    bit       m_fv;
    int       m_fidx;
    int       m_phase; // 0 idle, 1 clearing, 2 acknowledging

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_d = 0; m_sticky = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_irq[0] = 0; m_irq[1] = 0;
        m_fv = 0; m_fidx = 0; m_phase = 0;
    endfunction

    function automatic void model_edge(input bit [7:0] e, input bit en,
                                       input bit req);
        bit [7:0] rise = m_q & ~m_d;
        bit       upd  = en && (rise != 0) && (m_phase != 1);
        if (m_phase == 1) begin
            m_sticky = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_irq[0] = 0; m_irq[1] = 0;
            m_fv = 0; m_fidx = 0;
        end else begin
            if (en) m_sticky |= m_q;
            if (upd) begin
                for (int w = 0; w < 2; w++) begin
                    int lim = (w == 0) ? 65535 : 15;
                    int t   = (w == 0) ? int'(th) : int'(th) % 16;
                    if (m_cnt[w] < lim) m_cnt[w] = m_cnt[w] + 1;
                    if (t != 0 && m_cnt[w] >= t) m_irq[w] = 1;
                end
                if (!m_fv) begin
                    m_fv = 1;
                    for (int i = 7; i >= 0; i--)
                        if (rise[i]) m_fidx = i;
                end
            end
        end
        case (m_phase)
            0: if (req) m_phase = 1;
            1: m_phase = 2;
            default: if (!req) m_phase = 0;
        endcase
        m_d = m_q;
        m_q = e;
    endfunction

    task automatic compare_all();
        chk("sticky",   32'(bus16.sticky_o),      32'(m_sticky));
        chk("cnt16",    32'(bus16.err_cnt_o),     32'(m_cnt[0]));
        chk("sat16",    32'(bus16.cnt_sat_o),     32'(m_cnt[0] == 65535));
        chk("fvalid",   32'(bus16.first_valid_o), 32'(m_fv));
        chk("fidx",     32'(bus16.first_idx_o),   32'(m_fidx));
        chk("irq16",    32'(bus16.irq_o),         32'(m_irq[0]));
        chk("ack16",    32'(bus16.clr_ack_o),     32'(m_phase == 2));
        chk("cnt4",     32'(bus4.err_cnt_o),      32'(m_cnt[1]));
        chk("sat4",     32'(bus4.cnt_sat_o),      32'(m_cnt[1] == 15));
        chk("irq4",     32'(bus4.irq_o),          32'(m_irq[1]));
        chk("ack4",     32'(bus4.clr_ack_o),      32'(m_phase == 2));
    endtask

    task automatic set_in(input bit [7:0] e, input bit en, input bit req);
        bus16.err_i     = e;
        bus16.enable_i  = en;
        bus16.thresh_i  = th;
        bus16.clr_req_i = req;
        bus4.err_i      = e;
        bus4.enable_i   = en;
        bus4.thresh_i   = th[3:0];
        bus4.clr_req_i  = req;
    endtask

    task automatic step(input bit [7:0] e, input bit en = 1'b1,
                        input bit req = 1'b0);
        set_in(e, en, req);
        model_edge(e, en, req);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input bit [7:0] e);
        rst = 1'b1;
        set_in(e, 1'b1, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    task automatic do_clear();
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("clr_ack_hi", 32'(bus16.clr_ack_o), 32'd1);
        chk("clr_cnt0",   32'(bus16.err_cnt_o), 32'd0);
        step(8'h00, 1'b1, 1'b0);
        chk("clr_ack_lo", 32'(bus16.clr_ack_o), 32'd0);
        step(8'h00);
    endtask

    initial begin
        bit [7:0] e;
        bit       en;
        bit       req;

        th  = 16'd0;
        rst = 1'b1;
        set_in(8'h00, 1'b0, 1'b0);
        do_reset(8'h00);

        // single-cycle pulse on voter 5
        step(8'h20);
        step(8'h00);
        chk("t1_sticky", 32'(bus16.sticky_o),      32'h20);
        chk("t1_cnt",    32'(bus16.err_cnt_o),     32'd1);
        chk("t1_fidx",   32'(bus16.first_idx_o),   32'd5);
        chk("t1_fvalid", 32'(bus16.first_valid_o), 32'd1);
        chk("t1_irq",    32'(bus16.irq_o),         32'd0);

        // held level counts once; re-raise counts again
        repeat (10) step(8'h04);
        chk("t2_cnt_hold", 32'(bus16.err_cnt_o), 32'd2);
        chk("t2_sticky",   32'(bus16.sticky_o),  32'h24);
        step(8'h00);
        step(8'h00);
        step(8'h04);
        step(8'h00);
        step(8'h00);
        chk("t2_cnt_rerise", 32'(bus16.err_cnt_o), 32'd3);

        // simultaneous rise picks lowest index; later event keeps it
        do_clear();
        step(8'h42);
        step(8'h00);
        step(8'h00);
        chk("t3_cnt",  32'(bus16.err_cnt_o),   32'd1);
        chk("t3_fidx", 32'(bus16.first_idx_o), 32'd1);
        step(8'h01);
        step(8'h00);
        chk("t3_fidx_keep", 32'(bus16.first_idx_o), 32'd1);

        // threshold irq, sticky across a threshold raise
        do_clear();
        th = 16'd3;
        step(8'h01); step(8'h00);
        step(8'h02); step(8'h00);
        chk("t4_irq_pre", 32'(bus16.irq_o), 32'd0);
        step(8'h04); step(8'h00);
        chk("t4_irq", 32'(bus16.irq_o),     32'd1);
        chk("t4_cnt", 32'(bus16.err_cnt_o), 32'd3);
        th = 16'd10;
        step(8'h00);
        step(8'h00);
        chk("t4_irq_keep", 32'(bus16.irq_o), 32'd1);

        // 4-bit counter saturation
        do_clear();
        th = 16'd0;
        repeat (20) begin
            step(8'h80);
            step(8'h00);
        end
        chk("t5_cnt4", 32'(bus4.err_cnt_o), 32'd15);
        chk("t5_sat4", 32'(bus4.cnt_sat_o), 32'd1);
        chk("t5_cnt16", 32'(bus16.err_cnt_o), 32'd20);

        // event lands in CLR cycle and is dropped; event in ACK counts
        step(8'h08, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("t6_ack",    32'(bus16.clr_ack_o), 32'd1);
        chk("t6_cnt",    32'(bus16.err_cnt_o), 32'd0);
        chk("t6_sticky", 32'(bus16.sticky_o),  32'd0);
        step(8'h00, 1'b1, 1'b1);
        step(8'h02, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("t6_cnt_ack", 32'(bus16.err_cnt_o), 32'd1);
        chk("t6_ack_hold", 32'(bus16.clr_ack_o), 32'd1);
        #2 rst = 1'b1;
        #1 chk("t6_ack_async", 32'(bus16.clr_ack_o), 32'd0);
        chk("t6_cnt_async", 32'(bus16.err_cnt_o), 32'd0);
        do_reset(8'h00);

        // error held across reset release is one event
        do_reset(8'h10);
        step(8'h10);
        step(8'h10);
        step(8'h00);
        chk("t7_cnt", 32'(bus16.err_cnt_o), 32'd1);

        // random traffic
        req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(8'($urandom));
                req = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) th = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) req = ~req;
            e  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            en = ($urandom_range(0, 9) != 0);
            step(e, en, req);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
